// File: rtl/sequence_entry_controller.sv
// sequence_entry_controller: checks each key press against the stored pattern and reports pass, fail or timeout
module sequence_entry_controller #(
  parameter int MAX_LEN        = 16,
  parameter int IDX_W          = 4,
  parameter int LEN_W          = 5,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int TO_W           = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] seq_len,
  input  logic [15:0]      value,
  input  logic             valueReady,
  output logic [IDX_W-1:0] exp_addr,
  input  logic [3:0]       exp_data,
  output logic             busy,
  output logic [IDX_W-1:0] entry_idx,
  output logic             key_accept,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_KEY, CHECK, FINISH} state_t;
  state_t           state;
  logic [LEN_W-1:0] len;
  logic [IDX_W-1:0] idx;
  logic [3:0]       code;
  logic [TO_W-1:0]  cnt;
  logic             vr_q;
  logic             key_evt;
  logic             unused_ok;
  assign key_evt   = valueReady & ~vr_q;
  assign busy      = state != IDLE;
  assign entry_idx = idx;
  assign unused_ok = ^value[15:4];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      idx        <= '0;
      code       <= '0;
      cnt        <= '0;
      vr_q       <= 1'b1;
      exp_addr   <= '0;
      key_accept <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      vr_q       <= valueReady;
      key_accept <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len      <= seq_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : seq_len;
          pass     <= seq_len == '0;
          fail     <= 1'b0;
          timeout  <= 1'b0;
          idx      <= '0;
          exp_addr <= '0;
          state    <= seq_len == '0 ? FINISH : FETCH;
        end
        FETCH: begin
          cnt   <= '0;
          state <= WAIT_KEY;
        end
        WAIT_KEY: if (key_evt) begin
          code  <= value[3:0];
          state <= CHECK;
        end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout <= 1'b1;
          state   <= FINISH;
        end else begin
          cnt <= cnt + TO_W'(1);
        end
        CHECK: if (code != exp_data) begin
          fail  <= 1'b1;
          state <= FINISH;
        end else if (LEN_W'(idx) == len - LEN_W'(1)) begin
          key_accept <= 1'b1;
          pass       <= 1'b1;
          state      <= FINISH;
        end else begin
          key_accept <= 1'b1;
          idx        <= idx + IDX_W'(1);
          exp_addr   <= idx + IDX_W'(1);
          state      <= FETCH;
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sequence_entry_controller.sv
// tb_sequence_entry_controller: scoreboard bench for sequence_entry_controller
module tb_sequence_entry_controller;
  logic        clk, rst, start, valueReady, busy, key_accept, done, pass, fail, timeout;
  logic [4:0]  seq_len;
  logic [15:0] value;
  logic [3:0]  exp_addr, exp_data, entry_idx;
  logic [3:0]  mem [16] = '{4'd0, 4'd4, 4'd7, 4'd0, 4'd9, 4'd2, 4'd5, 4'd8,
                            4'd11, 4'd14, 4'd1, 4'd3, 4'd6, 4'd10, 4'd12, 4'd15};
  int          cyc = 0, total = 0, passed = 0;
  typedef struct {bit kind; int idx; logic [2:0] pft; int cyc;} exp_t;
  exp_t        sb [$];
  exp_t        e;
  sequence_entry_controller #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .value(value),
    .valueReady(valueReady), .exp_addr(exp_addr), .exp_data(exp_data), .busy(busy),
    .entry_idx(entry_idx), .key_accept(key_accept), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) exp_data <= mem[exp_addr];
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
  endtask
  always @(negedge clk) begin
    if (key_accept || done) begin
      if (sb.size() == 0) chk("unexpected_pulse", {key_accept, done}, 0);
      else begin
        e = sb.pop_front();
        chk("pulse_kind", int'(done), int'(e.kind));
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_entry_idx", int'(entry_idx), e.idx);
        if (e.kind) chk("result_pft", int'({pass, fail, timeout}), int'(e.pft));
      end
    end
  end
  task automatic do_start(input logic [4:0] n, output int s);
    @(posedge clk); #1;
    seq_len = n;
    start = 1;
    s = cyc;
    if (n == 0) sb.push_back('{1'b1, 0, 3'b100, s + 2});
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic press(input logic [3:0] k, input int acc_idx, input logic [2:0] pft, input int done_idx);
    @(posedge clk); #1;
    value = {12'h0, k};
    valueReady = 1;
    if (acc_idx >= 0) sb.push_back('{1'b0, acc_idx, 3'b000, cyc + 2});
    if (pft != 3'b000) sb.push_back('{1'b1, done_idx, pft, cyc + 3});
    repeat (8) @(posedge clk);
    #1 valueReady = 0;
    repeat (10) @(posedge clk);
  endtask
  task automatic wait_idle;
    int n = 0;
    #1;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("round_ends", int'(busy), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int s;
    rst = 1; start = 0; seq_len = 0; value = 0; valueReady = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_exp_addr", int'(exp_addr), 0);
    chk("reset_entry_idx", int'(entry_idx), 0);
    chk("reset_flags", int'({pass, fail, timeout, done, key_accept}), 0);
    rst = 0;
    do_start(4, s);
    press(0, 1, 3'b000, 0);
    press(4, 2, 3'b000, 0);
    press(7, 3, 3'b000, 0);
    press(0, 3, 3'b100, 3);
    wait_idle();
    do_start(4, s);
    press(0, 1, 3'b000, 0);
    press(5, -1, 3'b010, 1);
    wait_idle();
    do_start(4, s);
    sb.push_back('{1'b1, 0, 3'b001, s + 53});
    wait_idle();
    @(posedge clk); #1;
    valueReady = 1;
    repeat (3) @(posedge clk);
    do_start(1, s);
    repeat (5) @(posedge clk);
    #1 valueReady = 0;
    repeat (5) @(posedge clk);
    press(0, 0, 3'b100, 0);
    wait_idle();
    do_start(4, s);
    press(0, 1, 3'b000, 0);
    @(posedge clk); #1;
    seq_len = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midstart_entry_idx", int'(entry_idx), 1);
    chk("midstart_busy", int'(busy), 1);
    press(4, 2, 3'b000, 0);
    press(7, 3, 3'b000, 0);
    press(0, 3, 3'b100, 3);
    wait_idle();
    do_start(0, s);
    wait_idle();
    do_start(20, s);
    for (int i = 0; i < 16; i++)
      press(mem[i], i == 15 ? 15 : i + 1, i == 15 ? 3'b100 : 3'b000, 15);
    wait_idle();
    do_start(4, s);
    press(0, 1, 3'b000, 0);
    press(4, 2, 3'b000, 0);
    @(posedge clk); #1;
    chk("pre_reset_entry_idx", int'(entry_idx), 2);
    rst = 1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_exp_addr", int'(exp_addr), 0);
    chk("abort_entry_idx", int'(entry_idx), 0);
    chk("abort_flags", int'({pass, fail, timeout, done, key_accept}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
